// File: rtl/alu_collect_pkg.sv
// Shared encodings and decode helpers for the ALU result collector.
// Optional statistics outputs are built when ALU_COLLECT_STATS_EN is defined.
package alu_collect_pkg;

    localparam int unsigned CMD_W = 4;

    // Arithmetic commands (MODE = 1)
    localparam logic [CMD_W-1:0] CMD_ADD     = 4'd0;
    localparam logic [CMD_W-1:0] CMD_SUB     = 4'd1;
    localparam logic [CMD_W-1:0] CMD_ADD_CIN = 4'd2;
    localparam logic [CMD_W-1:0] CMD_SUB_CIN = 4'd3;
    localparam logic [CMD_W-1:0] CMD_INC_A   = 4'd4;
    localparam logic [CMD_W-1:0] CMD_DEC_A   = 4'd5;
    localparam logic [CMD_W-1:0] CMD_INC_B   = 4'd6;
    localparam logic [CMD_W-1:0] CMD_DEC_B   = 4'd7;
    localparam logic [CMD_W-1:0] CMD_CMP     = 4'd8;
    localparam logic [CMD_W-1:0] CMD_MUL_IN  = 4'd9;
    localparam logic [CMD_W-1:0] CMD_MUL_S   = 4'd10;

    // Logical commands (MODE = 0)
    localparam logic [CMD_W-1:0] CMD_AND     = 4'd0;
    localparam logic [CMD_W-1:0] CMD_NAND    = 4'd1;
    localparam logic [CMD_W-1:0] CMD_OR      = 4'd2;
    localparam logic [CMD_W-1:0] CMD_NOR     = 4'd3;
    localparam logic [CMD_W-1:0] CMD_XOR     = 4'd4;
    localparam logic [CMD_W-1:0] CMD_XNOR    = 4'd5;
    localparam logic [CMD_W-1:0] CMD_NOT_A   = 4'd6;
    localparam logic [CMD_W-1:0] CMD_NOT_B   = 4'd7;
    localparam logic [CMD_W-1:0] CMD_SHR1_A  = 4'd8;
    localparam logic [CMD_W-1:0] CMD_SHL1_A  = 4'd9;
    localparam logic [CMD_W-1:0] CMD_SHR1_B  = 4'd10;
    localparam logic [CMD_W-1:0] CMD_SHL1_B  = 4'd11;
    localparam logic [CMD_W-1:0] CMD_ROL     = 4'd12;
    localparam logic [CMD_W-1:0] CMD_ROR     = 4'd13;

    // Operand tracker states
    localparam logic [0:0] ST_IDLE      = 1'b0;
    localparam logic [0:0] ST_WAIT_OPND = 1'b1;

    // Multiply commands take the longer ALU latency
    function automatic logic is_mul(input logic mode, input logic [CMD_W-1:0] cmd);
        return mode && (cmd == CMD_MUL_IN || cmd == CMD_MUL_S);
    endfunction

    // Single-operand commands never wait for the second operand
    function automatic logic needs_both(input logic mode, input logic [CMD_W-1:0] cmd);
        if (mode)
            return !(cmd inside {CMD_INC_A, CMD_DEC_A, CMD_INC_B, CMD_DEC_B});
        else
            return !(cmd inside {CMD_NOT_A, CMD_NOT_B, CMD_SHR1_A, CMD_SHL1_A,
                                 CMD_SHR1_B, CMD_SHL1_B});
    endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO; push while full is accepted only alongside a pop.
module alu_result_fifo #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Storage and pointer update
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/alu_result_collector.sv
// Snoops ALU issue, samples ALU outputs when each result is due, and queues them.
// Define ALU_COLLECT_STATS_EN to add the cap_cnt/drop_cnt/to_cnt statistics outputs.
module alu_result_collector
    import alu_collect_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CMD_WIDTH = 4,
    parameter int unsigned LAT_STD   = 1,
    parameter int unsigned LAT_MUL   = 2,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CE,
    input  logic                 MODE,
    input  logic [CMD_WIDTH-1:0] CMD,
    input  logic [1:0]           INP_VALID,
    input  logic [WIDTH:0]       RES,
    input  logic                 COUT,
    input  logic                 OFLOW,
    input  logic                 G,
    input  logic                 L,
    input  logic                 E,
    input  logic                 ERR,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [WIDTH+6:0]     res_data,
    output logic [CMD_WIDTH:0]   res_tag,
    output logic                 res_timeout,
    output logic                 drop
`ifdef ALU_COLLECT_STATS_EN
    ,
    output logic [15:0]          cap_cnt,
    output logic [15:0]          drop_cnt,
    output logic [7:0]           to_cnt
`endif
);
    localparam int unsigned DW   = WIDTH + 7;
    localparam int unsigned TW   = CMD_WIDTH + 1;
    localparam int unsigned FW   = DW + TW + 1;
    localparam int unsigned CNTW = $clog2(TIMEOUT + 1);
    localparam int unsigned LW   = $clog2(LAT_MUL + 1);

    logic [0:0]      state_q, state_d;
    logic [TW-1:0]   wtag_q, wtag_d;
    logic [CNTW-1:0] wcnt_q, wcnt_d;

    logic            sched_c;
    logic [LW-1:0]   sched_lat_c;
    logic [TW-1:0]   sched_tag_c;
    logic [TW-1:0]   cur_tag_c;
    logic            to_cap_c;
    logic            collide_c;

    // Delay line stages 1..LAT_MUL; the capture register below is its final stage
    logic [LAT_MUL:1] dl_v_q, dl_v_d;
    logic [TW-1:0]    dl_t_q [1:LAT_MUL];
    logic [TW-1:0]    dl_t_d [1:LAT_MUL];

    logic            cap_v_q;
    logic [DW-1:0]   cap_d_q;
    logic [TW-1:0]   cap_t_q;
    logic            cap_to_q;
    logic            drop_q;

    logic            fifo_full;
    logic            fifo_empty;
    logic            pop_c;
    logic            lost_c;
    logic [FW-1:0]   fifo_dout;

    function automatic logic [LW-1:0] op_lat(input logic m, input logic [CMD_W-1:0] c);
        return is_mul(m, c) ? LW'(LAT_MUL) : LW'(LAT_STD);
    endfunction

    assign cur_tag_c = {MODE, CMD};

    // Tracker state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            wtag_q  <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wtag_q  <= wtag_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Tracker next state: decide when an issued op is scheduled or times out
    always_comb begin
        state_d     = state_q;
        wtag_d      = wtag_q;
        wcnt_d      = wcnt_q;
        sched_c     = 1'b0;
        sched_lat_c = '0;
        sched_tag_c = cur_tag_c;
        to_cap_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (CE) begin
                    if (INP_VALID == 2'b00) begin
                        sched_c     = 1'b1;
                        sched_lat_c = LW'(1);
                    end else if (INP_VALID == 2'b11 || !needs_both(MODE, CMD_W'(CMD))) begin
                        sched_c     = 1'b1;
                        sched_lat_c = op_lat(MODE, CMD_W'(CMD));
                    end else begin
                        state_d = ST_WAIT_OPND;
                        wtag_d  = cur_tag_c;
                        wcnt_d  = '0;
                    end
                end
            end
            ST_WAIT_OPND: begin
                if (CE) begin
                    if (INP_VALID == 2'b11) begin
                        sched_c     = 1'b1;
                        sched_tag_c = wtag_q;
                        sched_lat_c = op_lat(wtag_q[TW-1], CMD_W'(wtag_q[CMD_WIDTH-1:0]));
                        state_d     = ST_IDLE;
                    end else if (wcnt_q == CNTW'(TIMEOUT - 1)) begin
                        to_cap_c = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        wcnt_d = wcnt_q + CNTW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Delay line shift with new issue inserted; an occupied slot is overwritten by the newer op
    always_comb begin
        dl_v_d = '0;
        for (int i = 1; i <= LAT_MUL; i++) dl_t_d[i] = '0;
        for (int i = 1; i < LAT_MUL; i++) begin
            dl_v_d[i] = dl_v_q[i+1];
            dl_t_d[i] = dl_t_q[i+1];
        end
        collide_c = 1'b0;
        for (int i = 1; i <= LAT_MUL; i++) begin
            if (sched_c && sched_lat_c == LW'(i)) begin
                collide_c = dl_v_d[i];
                dl_v_d[i] = 1'b1;
                dl_t_d[i] = sched_tag_c;
            end
        end
    end

    assign pop_c  = !fifo_empty && res_ready;
    assign lost_c = cap_v_q && fifo_full && !pop_c;

    // Delay line, capture register and drop pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            dl_v_q   <= '0;
            for (int i = 1; i <= LAT_MUL; i++) dl_t_q[i] <= '0;
            cap_v_q  <= 1'b0;
            cap_d_q  <= '0;
            cap_t_q  <= '0;
            cap_to_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            dl_v_q   <= dl_v_d;
            for (int i = 1; i <= LAT_MUL; i++) dl_t_q[i] <= dl_t_d[i];
            cap_v_q  <= dl_v_q[1] || to_cap_c;
            cap_d_q  <= {ERR, OFLOW, COUT, G, L, E, RES};
            cap_t_q  <= to_cap_c ? wtag_q : dl_t_q[1];
            cap_to_q <= to_cap_c;
            drop_q   <= collide_c || lost_c;
        end
    end

    alu_result_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (cap_v_q),
        .din   ({cap_to_q, cap_t_q, cap_d_q}),
        .pop   (pop_c),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign res_valid   = !fifo_empty;
    assign res_data    = fifo_dout[DW-1:0];
    assign res_tag     = fifo_dout[DW+TW-1:DW];
    assign res_timeout = fifo_dout[FW-1];
    assign drop        = drop_q;

`ifdef ALU_COLLECT_STATS_EN
    logic push_ok_c;
    assign push_ok_c = cap_v_q && (!fifo_full || pop_c);

    // Saturating event counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            cap_cnt  <= '0;
            drop_cnt <= '0;
            to_cnt   <= '0;
        end else begin
            if (push_ok_c && cap_cnt != 16'hFFFF) cap_cnt <= cap_cnt + 16'd1;
            if ((collide_c || lost_c) && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if (to_cap_c && to_cnt != 8'hFF) to_cnt <= to_cnt + 8'd1;
        end
    end
`endif

endmodule
